// File: rtl/mega_core_pkg.sv
// mega_core_pkg: shared opcode masks/matches, SREG bit indices and ALU op codes.
// Optional feature macro: MEGA_CORE_SREG_IO_EN (maps SREG at I/O address IO_SREG).
package mega_core_pkg;

  localparam int unsigned SREG_W = 5;
  localparam int unsigned SREG_C = 0;
  localparam int unsigned SREG_Z = 1;
  localparam int unsigned SREG_N = 2;
  localparam int unsigned SREG_V = 3;
  localparam int unsigned SREG_S = 4;

  localparam logic [5:0] IO_SREG = 6'h3F;

  // Register-register group: 6-bit opcode in [15:10]
  localparam logic [15:0] MASK_RR  = 16'hFC00;
  localparam logic [15:0] OP_SBC   = 16'h0800;
  localparam logic [15:0] OP_ADD   = 16'h0C00;
  localparam logic [15:0] OP_CP    = 16'h1400;
  localparam logic [15:0] OP_SUB   = 16'h1800;
  localparam logic [15:0] OP_ADC   = 16'h1C00;
  localparam logic [15:0] OP_AND   = 16'h2000;
  localparam logic [15:0] OP_EOR   = 16'h2400;
  localparam logic [15:0] OP_OR    = 16'h2800;
  localparam logic [15:0] OP_MOV   = 16'h2C00;

  // Immediate group on R16..R31: 4-bit opcode in [15:12]
  localparam logic [15:0] MASK_IMM = 16'hF000;
  localparam logic [15:0] OP_CPI   = 16'h3000;
  localparam logic [15:0] OP_SUBI  = 16'h5000;
  localparam logic [15:0] OP_ORI   = 16'h6000;
  localparam logic [15:0] OP_ANDI  = 16'h7000;
  localparam logic [15:0] OP_LDI   = 16'hE000;

  // Single-register and X-pointer group
  localparam logic [15:0] MASK_ONE = 16'hFE0F;
  localparam logic [15:0] OP_LDX   = 16'h900C;
  localparam logic [15:0] OP_STX   = 16'h920C;
  localparam logic [15:0] OP_COM   = 16'h9400;
  localparam logic [15:0] OP_INC   = 16'h9403;
  localparam logic [15:0] OP_DEC   = 16'h940A;

  // I/O and flow control
  localparam logic [15:0] MASK_IO  = 16'hF800;
  localparam logic [15:0] OP_IN    = 16'hB000;
  localparam logic [15:0] OP_OUT   = 16'hB800;
  localparam logic [15:0] MASK_JMP = 16'hF000;
  localparam logic [15:0] OP_RJMP  = 16'hC000;
  localparam logic [15:0] MASK_BR  = 16'hFC00;
  localparam logic [15:0] OP_BRBS  = 16'hF000;
  localparam logic [15:0] OP_BRBC  = 16'hF400;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND,
    ALU_OR,  ALU_EOR, ALU_COM, ALU_INC, ALU_DEC
  } alu_op_e;

  function automatic logic op_match(input logic [15:0] ir, input logic [15:0] mask,
                                    input logic [15:0] match);
    return (ir & mask) == match;
  endfunction

endpackage

// File: rtl/mega_core_alu.sv
// mega_core_alu: combinational 8-bit ALU returning result and updated C/Z/N/V/S.
module mega_core_alu
  import mega_core_pkg::*;
(
  input  logic [7:0]        a_i,
  input  logic [7:0]        b_i,
  input  logic              c_i,
  input  logic              z_i,
  input  alu_op_e           op_i,
  output logic [7:0]        res_o,
  output logic [SREG_W-1:0] flags_o
);

  logic [8:0] sum;
  logic       c;
  logic       v;

  // Result with 9th carry/borrow bit; C held and V cleared unless the op defines them
  always_comb begin
    sum = 9'd0;
    c   = c_i;
    v   = 1'b0;
    case (op_i)
      ALU_ADD, ALU_ADC: begin
        sum = {1'b0, a_i} + {1'b0, b_i} + 9'((op_i == ALU_ADC) & c_i);
        c   = sum[8];
        v   = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
      end
      ALU_SUB, ALU_SBC: begin
        sum = {1'b0, a_i} - {1'b0, b_i} - 9'((op_i == ALU_SBC) & c_i);
        c   = sum[8];
        v   = (a_i[7] != b_i[7]) && (sum[7] != a_i[7]);
      end
      ALU_AND: sum = {1'b0, a_i & b_i};
      ALU_OR:  sum = {1'b0, a_i | b_i};
      ALU_EOR: sum = {1'b0, a_i ^ b_i};
      ALU_COM: begin
        sum = {1'b0, ~a_i};
        c   = 1'b1;
      end
      ALU_INC: begin
        sum = {1'b0, a_i + 8'd1};
        v   = (sum[7:0] == 8'h80);
      end
      ALU_DEC: begin
        sum = {1'b0, a_i - 8'd1};
        v   = (sum[7:0] == 8'h7F);
      end
      default: sum = 9'd0;
    endcase
  end

  // Flag vector; SBC can only clear Z, never set it
  always_comb begin
    flags_o         = '0;
    flags_o[SREG_C] = c;
    flags_o[SREG_Z] = (sum[7:0] == 8'h00) && ((op_i != ALU_SBC) || z_i);
    flags_o[SREG_N] = sum[7];
    flags_o[SREG_V] = v;
    flags_o[SREG_S] = sum[7] ^ v;
  end

  assign res_o = sum[7:0];

endmodule

// File: rtl/mega_core.sv
// mega_core: single-cycle reduced AVR core; decode is combinational from pgm_data.
// Optional feature macro: MEGA_CORE_SREG_IO_EN (SREG visible at I/O address 0x3F).
module mega_core
  import mega_core_pkg::*;
#(
  parameter int unsigned bus_addr_pgm_width  = 11,
  parameter int unsigned bus_addr_data_width = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [bus_addr_pgm_width-1:0]  pgm_addr,
  input  logic [15:0]                    pgm_data,
  output logic                           data_re,
  output logic                           data_we,
  output logic [bus_addr_data_width-1:0] data_addr,
  input  logic [7:0]                     data_in,
  output logic [7:0]                     data_out,
  output logic                           io_re,
  output logic                           io_we,
  output logic [5:0]                     io_addr,
  output logic [7:0]                     io_out,
  input  logic [7:0]                     io_in
);

  localparam int unsigned PW = bus_addr_pgm_width;
  localparam int unsigned DW = bus_addr_data_width;

  logic [PW-1:0]     pc_q, pc_d;
  logic [7:0]        rf_q [32];
  logic [SREG_W-1:0] sreg_q, sreg_d;
  logic              sreg_we;
  logic              rf_we;
  logic [4:0]        rf_wa;
  logic [7:0]        rf_wd;

  alu_op_e           alu_op;
  logic [7:0]        alu_a, alu_b, alu_res;
  logic [SREG_W-1:0] alu_flags;

  logic [15:0]       ir;
  logic [4:0]        d_idx, r_idx, dh_idx;
  logic [7:0]        k8;
  logic [5:0]        io_a;
  logic [7:0]        sreg8;
  logic              br_bit;

  assign pgm_addr = pc_q;
  assign ir       = pgm_data;
  assign d_idx    = ir[8:4];
  assign r_idx    = {ir[9], ir[3:0]};
  assign dh_idx   = {1'b1, ir[7:4]};
  assign k8       = {ir[11:8], ir[3:0]};
  assign io_a     = {ir[10:9], ir[3:0]};
  assign sreg8    = {3'b000, sreg_q};
  assign br_bit   = sreg8[ir[2:0]];

  mega_core_alu u_alu (
    .a_i     (alu_a),
    .b_i     (alu_b),
    .c_i     (sreg_q[SREG_C]),
    .z_i     (sreg_q[SREG_Z]),
    .op_i    (alu_op),
    .res_o   (alu_res),
    .flags_o (alu_flags)
  );

  // Instruction decode: next PC, writeback controls and bus strobes
  always_comb begin
    pc_d      = pc_q + PW'(1);
    alu_op    = ALU_ADD;
    alu_a     = rf_q[d_idx];
    alu_b     = rf_q[r_idx];
    rf_we     = 1'b0;
    rf_wa     = d_idx;
    rf_wd     = alu_res;
    sreg_we   = 1'b0;
    sreg_d    = alu_flags;
    data_re   = 1'b0;
    data_we   = 1'b0;
    data_addr = '0;
    data_out  = 8'h00;
    io_re     = 1'b0;
    io_we     = 1'b0;
    io_addr   = 6'h00;
    io_out    = 8'h00;

    if (op_match(ir, MASK_RR, OP_ADD)) begin
      alu_op = ALU_ADD; sreg_we = 1'b1; rf_we = 1'b1;
    end else if (op_match(ir, MASK_RR, OP_ADC)) begin
      alu_op = ALU_ADC; sreg_we = 1'b1; rf_we = 1'b1;
    end else if (op_match(ir, MASK_RR, OP_SUB)) begin
      alu_op = ALU_SUB; sreg_we = 1'b1; rf_we = 1'b1;
    end else if (op_match(ir, MASK_RR, OP_SBC)) begin
      alu_op = ALU_SBC; sreg_we = 1'b1; rf_we = 1'b1;
    end else if (op_match(ir, MASK_RR, OP_CP)) begin
      alu_op = ALU_SUB; sreg_we = 1'b1;
    end else if (op_match(ir, MASK_RR, OP_AND)) begin
      alu_op = ALU_AND; sreg_we = 1'b1; rf_we = 1'b1;
    end else if (op_match(ir, MASK_RR, OP_OR)) begin
      alu_op = ALU_OR; sreg_we = 1'b1; rf_we = 1'b1;
    end else if (op_match(ir, MASK_RR, OP_EOR)) begin
      alu_op = ALU_EOR; sreg_we = 1'b1; rf_we = 1'b1;
    end else if (op_match(ir, MASK_RR, OP_MOV)) begin
      rf_we = 1'b1; rf_wd = rf_q[r_idx];
    end else if (op_match(ir, MASK_IMM, OP_LDI)) begin
      rf_we = 1'b1; rf_wa = dh_idx; rf_wd = k8;
    end else if (op_match(ir, MASK_IMM, OP_SUBI) || op_match(ir, MASK_IMM, OP_CPI)) begin
      alu_op = ALU_SUB; alu_a = rf_q[dh_idx]; alu_b = k8; sreg_we = 1'b1;
      rf_wa  = dh_idx;  rf_we = op_match(ir, MASK_IMM, OP_SUBI);
    end else if (op_match(ir, MASK_IMM, OP_ANDI)) begin
      alu_op = ALU_AND; alu_a = rf_q[dh_idx]; alu_b = k8; sreg_we = 1'b1;
      rf_wa  = dh_idx;  rf_we = 1'b1;
    end else if (op_match(ir, MASK_IMM, OP_ORI)) begin
      alu_op = ALU_OR; alu_a = rf_q[dh_idx]; alu_b = k8; sreg_we = 1'b1;
      rf_wa  = dh_idx; rf_we = 1'b1;
    end else if (op_match(ir, MASK_ONE, OP_COM)) begin
      alu_op = ALU_COM; sreg_we = 1'b1; rf_we = 1'b1;
    end else if (op_match(ir, MASK_ONE, OP_INC)) begin
      alu_op = ALU_INC; sreg_we = 1'b1; rf_we = 1'b1;
    end else if (op_match(ir, MASK_ONE, OP_DEC)) begin
      alu_op = ALU_DEC; sreg_we = 1'b1; rf_we = 1'b1;
    end else if (op_match(ir, MASK_ONE, OP_LDX)) begin
      data_re = 1'b1; data_addr = DW'({rf_q[27], rf_q[26]});
      rf_we   = 1'b1; rf_wd = data_in;
    end else if (op_match(ir, MASK_ONE, OP_STX)) begin
      data_we = 1'b1; data_addr = DW'({rf_q[27], rf_q[26]});
      data_out = rf_q[d_idx];
    end else if (op_match(ir, MASK_IO, OP_IN)) begin
`ifdef MEGA_CORE_SREG_IO_EN
      if (io_a == IO_SREG) begin
        rf_we = 1'b1; rf_wd = sreg8;
      end else
`endif
      begin
        io_re = 1'b1; io_addr = io_a; rf_we = 1'b1; rf_wd = io_in;
      end
    end else if (op_match(ir, MASK_IO, OP_OUT)) begin
`ifdef MEGA_CORE_SREG_IO_EN
      if (io_a == IO_SREG) begin
        sreg_we = 1'b1; sreg_d = rf_q[d_idx][SREG_W-1:0];
      end else
`endif
      begin
        io_we = 1'b1; io_addr = io_a; io_out = rf_q[d_idx];
      end
    end else if (op_match(ir, MASK_JMP, OP_RJMP)) begin
      pc_d = pc_q + PW'(1) + PW'($signed(ir[11:0]));
    end else if (op_match(ir, MASK_BR, OP_BRBS)) begin
      if (br_bit) pc_d = pc_q + PW'(1) + PW'($signed(ir[9:3]));
    end else if (op_match(ir, MASK_BR, OP_BRBC)) begin
      if (!br_bit) pc_d = pc_q + PW'(1) + PW'($signed(ir[9:3]));
    end

    // Reset silences the bus even though decode is combinational
    if (rst) begin
      rf_we     = 1'b0;
      sreg_we   = 1'b0;
      data_re   = 1'b0;
      data_we   = 1'b0;
      data_addr = '0;
      data_out  = 8'h00;
      io_re     = 1'b0;
      io_we     = 1'b0;
      io_addr   = 6'h00;
      io_out    = 8'h00;
    end
  end

  // Architectural state: PC, SREG and register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      sreg_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 8'h00;
    end else begin
      pc_q <= pc_d;
      if (sreg_we) sreg_q <= sreg_d;
      if (rf_we) rf_q[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_mega_core.sv
// tb_mega_core: runs a small program; bus events go through a scoreboard queue,
// register/flag/PC state is compared against hand-derived values per clock.
module tb_mega_core;

  logic        clk;
  logic        rst;
  logic [10:0] pgm_addr;
  logic [15:0] pgm_data;
  logic        data_re, data_we;
  logic [7:0]  data_addr, data_in, data_out;
  logic        io_re, io_we;
  logic [5:0]  io_addr;
  logic [7:0]  io_out, io_in;

  logic [15:0] rom [2048];
  logic [7:0]  ram [256];
  logic [7:0]  io_reg;
  logic [18:0] sb_q [$];
  logic [19:0] obs, expv;
  int          n_total = 0;
  int          n_bad   = 0;

  mega_core dut (
    .clk       (clk),
    .rst       (rst),
    .pgm_addr  (pgm_addr),
    .pgm_data  (pgm_data),
    .data_re   (data_re),
    .data_we   (data_we),
    .data_addr (data_addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .io_re     (io_re),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_out    (io_out),
    .io_in     (io_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program ROM, data RAM and a single loopback I/O register
  assign pgm_data = rom[pgm_addr];
  assign data_in  = data_re ? ram[data_addr] : 8'h00;
  assign io_in    = io_reg;

  initial io_reg = 8'h00;

  always @(posedge clk) begin
    if (data_we) ram[data_addr] <= data_out;
    if (io_we) io_reg <= io_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // kind: 1 io write, 2 data write, 3 io read, 4 data read
  task automatic sb_push(input logic [2:0] kind, input logic [7:0] addr, input logic [7:0] data);
    sb_q.push_back({kind, addr, data});
  endtask

  function automatic logic [15:0] e_rr(input logic [5:0] op, input logic [4:0] d, input logic [4:0] r);
    return {op, r[4], d, r[3:0]};
  endfunction
  // d4 selects R16+d4
  function automatic logic [15:0] e_imm(input logic [3:0] op, input logic [3:0] d4, input logic [7:0] k);
    return {op, k[7:4], d4, k[3:0]};
  endfunction
  function automatic logic [15:0] e_one(input logic [4:0] d, input logic [3:0] lo);
    return {7'b1001010, d, lo};
  endfunction
  function automatic logic [15:0] e_ld(input logic [4:0] d);
    return {7'b1001000, d, 4'hC};
  endfunction
  function automatic logic [15:0] e_st(input logic [4:0] r);
    return {7'b1001001, r, 4'hC};
  endfunction
  function automatic logic [15:0] e_in(input logic [4:0] d, input logic [5:0] a);
    return {5'b10110, a[5:4], d, a[3:0]};
  endfunction
  function automatic logic [15:0] e_out(input logic [5:0] a, input logic [4:0] r);
    return {5'b10111, a[5:4], r, a[3:0]};
  endfunction
  function automatic logic [15:0] e_br(input logic clr, input logic [2:0] s, input logic [6:0] k);
    return {5'b11110, clr, k, s};
  endfunction
  function automatic logic [15:0] e_rjmp(input logic [11:0] k);
    return {4'hC, k};
  endfunction

  // Bus monitor: every strobe cycle must match the next scoreboard entry
  initial forever begin
    @(negedge clk);
    if (!rst && (io_we || io_re || data_we || data_re)) begin
      if (io_we)        obs = {1'b1, 3'd1, 2'b00, io_addr, io_out};
      else if (data_we) obs = {1'b1, 3'd2, data_addr, data_out};
      else if (io_re)   obs = {1'b1, 3'd3, 2'b00, io_addr, io_out};
      else              obs = {1'b1, 3'd4, data_addr, data_out};
      if (sb_q.size() == 0) expv = 20'h0;
      else                  expv = {1'b1, sb_q.pop_front()};
      check("bus_evt", 32'(obs), 32'(expv));
    end
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;

    rom[0]  = e_out(6'h05, 5'd0);
    rom[3]  = e_imm(4'hE, 4'd0, 8'h55);
    rom[4]  = e_out(6'h00, 5'd16);
    rom[5]  = e_in(5'd17, 6'h00);
    rom[6]  = e_imm(4'hE, 4'd0, 8'hFF);
    rom[7]  = e_imm(4'hE, 4'd1, 8'h01);
    rom[8]  = e_rr(6'b000011, 5'd16, 5'd17);
    rom[9]  = e_imm(4'hE, 4'd2, 8'h7F);
    rom[10] = e_one(5'd18, 4'h3);
    rom[11] = e_imm(4'hE, 4'd10, 8'h10);
    rom[12] = e_imm(4'hE, 4'd0, 8'hA5);
    rom[13] = e_st(5'd16);
    rom[14] = e_ld(5'd20);
    rom[15] = e_imm(4'hE, 4'd0, 8'h03);
    rom[16] = e_one(5'd16, 4'hA);
    rom[17] = e_br(1'b1, 3'd1, 7'h7E);
    rom[18] = e_imm(4'hE, 4'd5, 8'h10);
    rom[19] = e_imm(4'hE, 4'd6, 8'h20);
    rom[20] = e_rr(6'b000110, 5'd21, 5'd22);
    rom[21] = e_rr(6'b000010, 5'd21, 5'd21);
    rom[22] = e_imm(4'h7, 4'd5, 8'h0F);
    rom[23] = e_imm(4'h6, 4'd5, 8'h80);
    rom[24] = e_one(5'd21, 4'h0);
    rom[25] = e_imm(4'h3, 4'd5, 8'h70);
    rom[26] = e_in(5'd0, 6'h3F);
    rom[27] = e_out(6'h02, 5'd21);
    rom[28] = e_out(6'h03, 5'd20);
    rom[29] = e_br(1'b0, 3'd0, 7'h05);
    rom[30] = e_br(1'b0, 3'd1, 7'h01);
    rom[31] = e_out(6'h3E, 5'd0);
    rom[32] = e_rjmp(12'hFFF);

    sb_push(3'd1, 8'h05, 8'h00);
    sb_push(3'd1, 8'h00, 8'h55);
    sb_push(3'd3, 8'h00, 8'h00);
    sb_push(3'd2, 8'h10, 8'hA5);
    sb_push(3'd4, 8'h10, 8'h00);
`ifndef MEGA_CORE_SREG_IO_EN
    sb_push(3'd3, 8'h3F, 8'h00);
`endif
    sb_push(3'd1, 8'h02, 8'h70);
    sb_push(3'd1, 8'h03, 8'hA5);

    #6 rst = 1'b1;
    #1;
    check("rst_pc", 32'(pgm_addr), 32'h0);
    check("rst_strobes", 32'({io_re, io_we, data_re, data_we}), 32'h0);
    #1 rst = 1'b0;

    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      case (k)
        1:  check("pc_nop1", 32'(pgm_addr), 32'd1);
        2:  check("pc_nop2", 32'(pgm_addr), 32'd2);
        6:  check("in_r17", 32'(dut.rf_q[17]), 32'h55);
        9: begin
          check("add_r16", 32'(dut.rf_q[16]), 32'h00);
          check("add_sreg", 32'(dut.sreg_q), 32'h03);
        end
        11: begin
          check("inc_r18", 32'(dut.rf_q[18]), 32'h80);
          check("inc_sreg", 32'(dut.sreg_q), 32'h0D);
        end
        15: check("ld_r20", 32'(dut.rf_q[20]), 32'hA5);
        18: check("brne_taken", 32'(pgm_addr), 32'd16);
        22: begin
          check("brne_fall", 32'(pgm_addr), 32'd18);
          check("dec_r16", 32'(dut.rf_q[16]), 32'h00);
          check("dec_sreg", 32'(dut.sreg_q), 32'h03);
        end
        25: begin
          check("sub_r21", 32'(dut.rf_q[21]), 32'hF0);
          check("sub_sreg", 32'(dut.sreg_q), 32'h15);
        end
        26: begin
          check("sbc_r21", 32'(dut.rf_q[21]), 32'hFF);
          check("sbc_sreg", 32'(dut.sreg_q), 32'h15);
        end
        27: begin
          check("andi_r21", 32'(dut.rf_q[21]), 32'h0F);
          check("andi_sreg", 32'(dut.sreg_q), 32'h01);
        end
        28: begin
          check("ori_r21", 32'(dut.rf_q[21]), 32'h8F);
          check("ori_sreg", 32'(dut.sreg_q), 32'h15);
        end
        29: begin
          check("com_r21", 32'(dut.rf_q[21]), 32'h70);
          check("com_sreg", 32'(dut.sreg_q), 32'h01);
        end
        30: begin
          check("cpi_r21", 32'(dut.rf_q[21]), 32'h70);
          check("cpi_sreg", 32'(dut.sreg_q), 32'h02);
        end
`ifdef MEGA_CORE_SREG_IO_EN
        31: check("in_sreg_r0", 32'(dut.rf_q[0]), 32'h02);
`else
        31: check("in_3f_r0", 32'(dut.rf_q[0]), 32'h55);
`endif
        35: check("breq_taken", 32'(pgm_addr), 32'd32);
        45: check("rjmp_hold", 32'(pgm_addr), 32'd32);
        default: ;
      endcase
    end

    // Asynchronous reset mid-cycle, then held across an edge at an OUT
    #2 rst = 1'b1;
    #1;
    check("arst_pc", 32'(pgm_addr), 32'h0);
    check("arst_r21", 32'(dut.rf_q[21]), 32'h00);
    check("arst_sreg", 32'(dut.sreg_q), 32'h00);
    check("arst_io_we", 32'(io_we), 32'h0);
    @(posedge clk);
    #1;
    check("arst_hold_pc", 32'(pgm_addr), 32'h0);
    check("arst_no_write", 32'(io_reg), 32'hA5);
    check("sb_left", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
